// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Brief    : Shared FP format constants, flag indices, divider FSM states and
//            operand decode helpers for the FP datapath.
// Revision : 1.0 - initial release
// ============================================================================
package fp_pkg;

    localparam int MANTISA_WIDTH  = 23;
    localparam int EXPONENT_WIDTH = 8;
    localparam int FP_WIDTH       = MANTISA_WIDTH + EXPONENT_WIDTH + 1;
    localparam int BIAS           = 2 ** (EXPONENT_WIDTH - 1) - 1;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_FINISH = 2'd2
    } div_state_t;

    typedef struct packed {
        logic                      sign;
        logic [EXPONENT_WIDTH-1:0] exp;
        logic [MANTISA_WIDTH-1:0]  frac;
    } fp_t;

    function automatic fp_t fp_unpack(input logic [FP_WIDTH-1:0] x);
        return fp_t'(x);
    endfunction

    // No denormal support: only an all-zero exponent and fraction is zero.
    function automatic logic fp_is_zero(input fp_t x);
        return (x.exp == '0) && (x.frac == '0);
    endfunction

    function automatic logic [3:0] fp_flags(input logic n, input logic z, input logic v);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = 1'b0;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_fp_mant.sv
`default_nettype none
// ============================================================================
// Module   : div_mant_restoring
// Brief    : Restoring shift-subtract mantissa divider, one quotient bit per step.
// Revision : 1.0 - initial release
// ============================================================================
module div_mant_restoring
    import fp_pkg::*;
#(
    parameter int MANT_WIDTH = MANTISA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [MANT_WIDTH:0]   mant_a,
    input  logic [MANT_WIDTH:0]   mant_b,
    output logic [MANT_WIDTH+1:0] q,
    output logic                  last
);

    localparam int                c_cnt_w = $clog2(MANT_WIDTH + 2);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(MANT_WIDTH + 1);

    // Remainder stays below 2*divisor, so one spare bit carries the trial sign.
    logic [MANT_WIDTH+2:0] r_rem;
    logic [MANT_WIDTH:0]   r_div;
    logic [MANT_WIDTH:0]   r_q;
    logic [c_cnt_w-1:0]    r_count;

    logic [MANT_WIDTH+2:0] w_trial;
    logic                  w_ge;

    assign w_trial = r_rem - {2'b00, r_div};
    assign w_ge    = ~w_trial[MANT_WIDTH+2];
    // Quotient including the bit resolved by the current step.
    assign q       = {r_q, w_ge};
    assign last    = (r_count == c_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem   <= '0;
            r_div   <= '0;
            r_q     <= '0;
            r_count <= '0;
        end else if (load) begin
            r_rem   <= {2'b00, mant_a};
            r_div   <= mant_b;
            r_q     <= '0;
            r_count <= '0;
        end else if (step) begin
            r_rem   <= w_ge ? {w_trial[MANT_WIDTH+1:0], 1'b0} : {r_rem[MANT_WIDTH+1:0], 1'b0};
            r_q     <= {r_q[MANT_WIDTH-1:0], w_ge};
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_fp.sv
`default_nettype none
// ============================================================================
// Module   : div_fp
// Brief    : Iterative FP divider res = a / b with start/done handshake, NZCV flags.
// Revision : 1.0 - initial release
// ============================================================================
module div_fp
    import fp_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [FP_WIDTH-1:0] a,
    input  logic [FP_WIDTH-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [FP_WIDTH-1:0] res_div,
    output logic [3:0]          flags_div
);

    localparam logic signed [EXPONENT_WIDTH+1:0] c_exp_max = (EXPONENT_WIDTH+2)'((1 << EXPONENT_WIDTH) - 1);
    localparam logic signed [EXPONENT_WIDTH+1:0] c_bias    = (EXPONENT_WIDTH+2)'(BIAS);
    localparam logic signed [EXPONENT_WIDTH+1:0] c_one     = (EXPONENT_WIDTH+2)'(1);
    localparam logic signed [EXPONENT_WIDTH+1:0] c_zero    = '0;

    div_state_t                       r_state;
    logic                             r_sign;
    logic signed [EXPONENT_WIDTH+1:0] r_exp_base;

    fp_t                              w_a;
    fp_t                              w_b;
    logic                             w_a_zero;
    logic                             w_b_zero;
    logic                             w_sign;
    logic signed [EXPONENT_WIDTH+1:0] w_exp_base;
    logic                             w_load;
    logic                             w_step;
    logic [MANTISA_WIDTH+1:0]         w_q;
    logic                             w_last;
    logic                             w_norm_hi;
    logic [MANTISA_WIDTH-1:0]         w_norm_mant;
    logic signed [EXPONENT_WIDTH+1:0] w_norm_exp;

    assign w_a        = fp_unpack(a);
    assign w_b        = fp_unpack(b);
    assign w_a_zero   = fp_is_zero(w_a);
    assign w_b_zero   = fp_is_zero(w_b);
    assign w_sign     = w_a.sign ^ w_b.sign;
    assign w_exp_base = $signed({2'b00, w_a.exp}) - $signed({2'b00, w_b.exp}) + c_bias;

    assign w_load = (r_state == ST_IDLE) && start && !w_a_zero && !w_b_zero;
    assign w_step = (r_state == ST_DIVIDE);

    div_mant_restoring #(
        .MANT_WIDTH (MANTISA_WIDTH)
    ) u_mant (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (w_load),
        .step   (w_step),
        .mant_a ({1'b1, w_a.frac}),
        .mant_b ({1'b1, w_b.frac}),
        .q      (w_q),
        .last   (w_last)
    );

    // Quotient lies in [1/2, 2): drop one extra bit when it is >= 1.
    assign w_norm_hi   = w_q[MANTISA_WIDTH+1];
    assign w_norm_mant = w_norm_hi ? w_q[MANTISA_WIDTH:1] : w_q[MANTISA_WIDTH-1:0];
    assign w_norm_exp  = w_norm_hi ? r_exp_base : (r_exp_base - c_one);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_sign     <= 1'b0;
            r_exp_base <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            res_div    <= '0;
            flags_div  <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sign     <= w_sign;
                        r_exp_base <= w_exp_base;
                        busy       <= 1'b1;
                        if (w_b_zero) begin
                            res_div   <= {w_sign, {EXPONENT_WIDTH{1'b1}}, {MANTISA_WIDTH{1'b0}}};
                            flags_div <= fp_flags(w_sign, 1'b0, 1'b1);
                            done      <= 1'b1;
                            r_state   <= ST_FINISH;
                        end else if (w_a_zero) begin
                            res_div   <= {w_sign, {EXPONENT_WIDTH{1'b0}}, {MANTISA_WIDTH{1'b0}}};
                            flags_div <= fp_flags(w_sign, 1'b1, 1'b0);
                            done      <= 1'b1;
                            r_state   <= ST_FINISH;
                        end else begin
                            r_state <= ST_DIVIDE;
                        end
                    end
                end
                ST_DIVIDE: begin
                    // Result is registered with the final quotient bit so done coincides with FINISH.
                    if (w_last) begin
                        done    <= 1'b1;
                        r_state <= ST_FINISH;
                        if (w_norm_exp >= c_exp_max) begin
                            res_div   <= {r_sign, {EXPONENT_WIDTH{1'b1}}, {MANTISA_WIDTH{1'b0}}};
                            flags_div <= fp_flags(r_sign, 1'b0, 1'b1);
                        end else if (w_norm_exp <= c_zero) begin
                            res_div   <= {r_sign, {EXPONENT_WIDTH{1'b0}}, {MANTISA_WIDTH{1'b0}}};
                            flags_div <= fp_flags(r_sign, 1'b1, 1'b0);
                        end else begin
                            res_div   <= {r_sign, w_norm_exp[EXPONENT_WIDTH-1:0], w_norm_mant};
                            flags_div <= fp_flags(r_sign, 1'b0, 1'b0);
                        end
                    end
                end
                ST_FINISH: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_fp.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_fp
// Brief    : Directed self-checking bench for div_fp.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_fp;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] res_div;
    logic [3:0]  flags_div;

    int errors = 0;
    int checks = 0;

    div_fp u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .res_div   (res_div),
        .flags_div (flags_div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation, measure edges from the start-sampling edge to done.
    task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] exp_res, input logic [3:0] exp_flags, input int exp_cycles);
        int   n;
        logic busy_ok;
        @(negedge clk);
        a     = va;
        b     = vb;
        start = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        start   = 1'b0;
        busy_ok = 1'b1;
        while (!done && n < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({tag, " cycles"}, 32'(n), 32'(exp_cycles));
        check({tag, " busy"}, {31'd0, busy_ok & busy}, 32'd1);
        check({tag, " res"}, res_div, exp_res);
        check({tag, " flags"}, {28'd0, flags_div}, {28'd0, exp_flags});
        @(negedge clk);
        check({tag, " pulse"}, {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        int   pulses;
        logic [31:0] cap_res;
        logic [3:0]  cap_flags;
        logic        saw_done;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("reset outputs", {busy, done, flags_div, res_div[25:0]}, 32'd0);
        check("reset res", res_div, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("6/2", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 26);
        run_op("1/3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 26);

        // Abort 6/2 with reset at DIVIDE cycle 10.
        @(negedge clk);
        a     = 32'h40C00000;
        b     = 32'h40000000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy/done/flags", {29'd0, busy, done, |flags_div}, 32'd0);
        check("abort res", res_div, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("abort no done", {31'd0, saw_done}, 32'd0);
        run_op("6/2 again", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 26);

        // start pulses while busy must be ignored.
        @(negedge clk);
        a     = 32'hBFC00000;
        b     = 32'h3F000000;
        start = 1'b1;
        @(negedge clk);
        pulses    = 0;
        cap_res   = '0;
        cap_flags = '0;
        for (int i = 0; i < 40; i++) begin
            if (i >= 4 && i < 10) begin
                start = 1'b1;
                a     = 32'h3F800000;
                b     = 32'h40400000;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                pulses++;
                cap_res   = res_div;
                cap_flags = flags_div;
            end
        end
        check("busy-start pulses", 32'(pulses), 32'd1);
        check("-1.5/0.5 res", cap_res, 32'hC0400000);
        check("-1.5/0.5 flags", {28'd0, cap_flags}, {28'd0, 4'b1000});
        check("busy-start idle", {31'd0, busy}, 32'd0);
        check("result held", res_div, 32'hC0400000);

        run_op("0/5", 32'h00000000, 32'h40A00000, 32'h00000000, 4'b0100, 1);
        run_op("1/0", 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0001, 1);
        run_op("ovf", 32'h7F000000, 32'h00800000, 32'h7F800000, 4'b0001, 26);
        run_op("unf", 32'h00800000, 32'h7F000000, 32'h00000000, 4'b0100, 26);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_fp.md
Name: div_fp

Overview:
- Iterative, multi-cycle floating-point divider, res = a / b, for the ALU's FP datapath. It is the inverse operation of the combinational FP multiplier.
- Uses the same packed format {sign, exponent, mantissa} and the same NZCV flag output convention as that multiplier.
- Uses a start/done handshake. A restoring shift-subtract loop produces one quotient bit per cycle.
- The FP execute stage stalls on busy.

Parameters:
MANTISA_WIDTH, 23, stored fraction bits (hidden 1 implied)
EXPONENT_WIDTH, 8, biased exponent bits; BIAS = 2^(EXPONENT_WIDTH-1)-1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  MANTISA_WIDTH+EXPONENT_WIDTH+1  dividend, packed
b  input  MANTISA_WIDTH+EXPONENT_WIDTH+1  divisor, packed
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse; res_div and flags_div are valid from this cycle
res_div  output  MANTISA_WIDTH+EXPONENT_WIDTH+1  quotient, packed
flags_div  output  4  {N,Z,C,V}

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is asynchronous and active-low on rst_n.
  - Reset values: state=IDLE; busy=0, done=0, res_div=0, flags_div=0; internal registers 0.
  - Reset mid-operation aborts the operation and drops the result. No done pulse is produced.
- Operand decode:
  - Sign is the MSB. Exponent is the next EXPONENT_WIDTH bits. Mantissa is {1'b1, fraction}.
  - An operand is zero iff exponent==0 and fraction==0.
  - No denormal, inf or NaN handling: exponent 0 with a nonzero fraction is treated as normal.
- Result sign: res_sign = sign_a ^ sign_b, always, including special cases.
- States:
  - IDLE: busy=0. On start=1, latch a and b.
    - If b is zero or a is zero, go to FINISH.
    - Otherwise load remainder = mantissa_a, divisor = mantissa_b, count = 0, and go to DIVIDE.
  - DIVIDE: exactly MANTISA_WIDTH+2 cycles (25 by default). Each cycle performs one restoring step:
    - trial = remainder - divisor.
    - If trial >= 0: quotient bit = 1 and remainder = trial << 1.
    - Else: quotient bit = 0 and remainder = remainder << 1.
    - Quotient bits shift in from the LSB.
    - The result is q = floor(mantissa_a * 2^(MANTISA_WIDTH+1) / mantissa_b), MANTISA_WIDTH+2 bits wide, with q in [2^M, 2^(M+2)).
    - After the last step, go to FINISH.
  - FINISH: register res_div and flags_div, pulse done=1, return to IDLE. busy is high in DIVIDE and FINISH.
- Normalisation (truncate, no rounding):
  - If q[M+1]=1: mant = q[M:1], exp = ea - eb + BIAS.
  - Else: mant = q[M-1:0], exp = ea - eb + BIAS - 1.
  - The exponent is computed signed, EXPONENT_WIDTH+2 bits wide.
- Special cases, in priority order:
  1. b zero: result {s, all-ones exponent, 0}, V=1.
  2. a zero: result {s, 0, 0}, Z=1.
  3. exp >= 2^EXPONENT_WIDTH - 1: result {s, all-ones, 0}, V=1.
  4. exp <= 0: result {s, 0, 0}, Z=1.
- Latency:
  - Normal operation: done is high in the cycle after edge M+3 counted from the start-sampling edge (26 cycles by default).
  - Zero operands: done is high after the next edge (1 cycle).
- Flags: N = res_sign. Z as defined above. C = 0 always. V as defined above.
- Handshake:
  - start while busy is ignored.
  - start in the same cycle as done is ignored, because the FSM is still in FINISH. It is accepted on the following cycle.
  - res_div and flags_div hold their values until the next FINISH.

Decomposition:
- Shared package fp_pkg holds:
  - MANTISA_WIDTH, EXPONENT_WIDTH, BIAS.
  - The flag bit indices N=3, Z=2, C=1, V=0.
  - The FSM state encoding (IDLE, DIVIDE, FINISH).
  - fp_unpack/zero-detect functions, reusable by the multiplier.
- One natural sub-module, div_mant_restoring: owns the remainder, quotient and counter, and exposes load, step and q.
- Normalisation, special cases and the FSM stay in div_fp.

Test Plan:
- 0x40C00000 / 0x40000000 (6.0/2.0) -> res 0x40400000, flags 0000, done after 26 cycles, busy high throughout.
- 0x3F800000 / 0x40400000 (1.0/3.0) -> res 0x3EAAAAAA (truncated), flags 0000.
- 0xBFC00000 / 0x3F000000 (-1.5/0.5) -> res 0xC0400000, flags 1000. Then assert start during busy and confirm it is ignored with exactly one done pulse.
- 0x00000000 / 0x40A00000 -> res 0x00000000, flags 0100, done after 1 cycle. Then 0x3F800000 / 0x00000000 -> res 0x7F800000, flags 0001.
- 0x7F000000 / 0x00800000 -> res 0x7F800000, flags 0001 (exponent overflow). Then 0x00800000 / 0x7F000000 -> res 0x00000000, flags 0100 (underflow).
- Deassert rst_n at DIVIDE cycle 10 of 6.0/2.0 -> all outputs 0 immediately, no done pulse. Then issue 6.0/2.0 again -> correct 0x40400000.
